// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM result collector: widths, FSM encoding and FIFO entry layout.
package smvm_pkg;

    localparam int DATA_W = 13;
    localparam int ROW_W  = 9;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/smvm_sync_fifo.sv
// Generic DEPTH x WIDTH register FIFO; a push into a full FIFO is accepted only alongside a pop.
module smvm_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW-1:0] L_PTR_INC = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   L_CNT_INC = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   L_CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == L_CNT_MAX);
    assign o_empty   = (r_count == {(AW+1){1'b0}});
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + L_PTR_INC;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_INC;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + L_CNT_INC;
                2'b01:   r_count <= r_count - L_CNT_INC;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Head read-out, forced to zero when empty
    always_comb begin
        if (o_empty) o_data = {WIDTH{1'b0}};
        else         o_data = r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/smvm_result_collector.sv
// Buffers SMVM row results for a host, counts rows per job and reports done/overflow.
// Optional macro SMVM_ROWIDX_EN adds a per-entry row index on out_row.
module smvm_result_collector
    import smvm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  rows_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef SMVM_ROWIDX_EN
    output logic [ROW_W-1:0]  out_row,
`endif
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ROW_W:0] L_ROW_INC = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [AW:0]    L_CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [ROW_W:0] r_rows;
    logic [ROW_W:0] r_row_cnt;
    logic [ROW_W:0] w_row_cnt_inc;
    logic           r_ovf;
    logic           w_full;
    logic           w_empty;
    logic [AW:0]    w_count;
    logic           w_pop;
    logic           w_beat;
    logic           w_drop;
    logic           w_start_ok;

    assign w_pop         = !w_empty && out_ready;
    assign w_beat        = (r_state == ST_COLLECT) && in_valid;
    assign w_drop        = w_beat && w_full && !w_pop;
    assign w_start_ok    = (r_state == ST_IDLE) && start;
    assign w_row_cnt_inc = r_row_cnt + L_ROW_INC;

`ifdef SMVM_ROWIDX_EN
    entry_t w_wr_entry;
    entry_t w_rd_entry;

    assign w_wr_entry.row  = r_row_cnt[ROW_W-1:0];
    assign w_wr_entry.data = in_data;
    assign out_data        = w_rd_entry.data;
    assign out_row         = w_rd_entry.row;

    smvm_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_beat),
        .i_pop   (w_pop),
        .i_data  (w_wr_entry),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
`else
    smvm_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_beat),
        .i_pop   (w_pop),
        .i_data  (in_data),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
`endif

    // Job sequencing; DRAIN ends on the cycle the last entry leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (rows_in != {ROW_W{1'b0}}) w_state_nxt = ST_COLLECT;
                    else                          w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (w_beat && (w_row_cnt_inc == r_rows)) w_state_nxt = ST_DRAIN;
                else                                     w_state_nxt = ST_COLLECT;
            end
            ST_DRAIN: begin
                if (w_empty || ((w_count == L_CNT_ONE) && w_pop)) w_state_nxt = ST_DONE;
                else                                             w_state_nxt = ST_DRAIN;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, row bookkeeping and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rows    <= {(ROW_W+1){1'b0}};
            r_row_cnt <= {(ROW_W+1){1'b0}};
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_rows    <= {1'b0, rows_in};
                r_row_cnt <= {(ROW_W+1){1'b0}};
                r_ovf     <= 1'b0;
            end else begin
                if (w_beat) r_row_cnt <= w_row_cnt_inc;
                if (w_drop) r_ovf     <= 1'b1;
            end
        end
    end

    assign out_valid = !w_empty;
    assign busy      = (r_state == ST_COLLECT) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_smvm_result_collector.sv
// Self-checking bench for smvm_result_collector: directed table, corner sequences, random vs. queue model.
module tb_smvm_result_collector;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [8:0]  rows_in;
    logic [12:0] in_data;
    logic        out_valid, busy, done, overflow;
    logic [12:0] out_data;
`ifdef SMVM_ROWIDX_EN
    logic [8:0]  out_row;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: job phase (0 idle, 1 collecting, 2 draining, 3 done)
    logic [21:0] m_q[$];
    int          m_mode = 0;
    int          m_rows = 0;
    int          m_cnt  = 0;
    logic        m_ovf  = 1'b0;

    always #5 clk = ~clk;

    smvm_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .rows_in(rows_in),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SMVM_ROWIDX_EN
        .out_row(out_row),
`endif
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic [8:0] r, input logic iv,
                              input logic [12:0] d, input logic rdy, input logic rs);
        int  pre;
        int  nmode;
        bit  pop, beat;
        if (rs) begin
            m_q.delete(); m_mode = 0; m_cnt = 0; m_ovf = 1'b0;
        end else begin
            pre   = m_q.size();
            pop   = (pre != 0) && rdy;
            beat  = (m_mode == 1) && iv;
            nmode = m_mode;
            if (m_mode == 0 && s) begin
                m_ovf = 1'b0;
                if (r != 9'd0) begin nmode = 1; m_rows = int'(r); m_cnt = 0; end
                else nmode = 3;
            end else if (m_mode == 1) begin
                if (beat && m_cnt + 1 == m_rows) nmode = 2;
            end else if (m_mode == 2) begin
                if (pre - int'(pop) == 0) nmode = 3;
            end else if (m_mode == 3) begin
                nmode = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (beat) begin
                if (pre < 16 || pop) m_q.push_back({m_cnt[8:0], d});
                else m_ovf = 1'b1;
                m_cnt++;
            end
            m_mode = nmode;
        end
    endtask

    task automatic model_check();
        logic [21:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 22'd0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        chk("out_data",  {19'd0, out_data},  {19'd0, head[12:0]});
        chk("busy",      {31'd0, busy},      {31'd0, (m_mode == 1 || m_mode == 2)});
        chk("done",      {31'd0, done},      {31'd0, (m_mode == 3)});
        chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
`ifdef SMVM_ROWIDX_EN
        chk("out_row",   {23'd0, out_row},   {23'd0, head[21:13]});
`endif
    endtask

    task automatic step(input logic s, input logic [8:0] r, input logic iv,
                        input logic [12:0] d, input logic rdy, input logic rs);
        start = s; rows_in = r; in_valid = iv; in_data = d; out_ready = rdy; rst = rs;
        @(posedge clk);
        model_edge(s, r, iv, d, rdy, rs);
        #1;
        model_check();
    endtask

    typedef struct {
        logic        st;
        logic [8:0]  rows;
        logic        iv;
        logic [12:0] d;
        logic        rdy;
        logic        e_valid;
        logic [12:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n;
        tbl[0] = '{1'b1, 9'd4, 1'b0, 13'h0000, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 9'd0, 1'b1, 13'h0010, 1'b1, 1'b1, 13'h0010, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 9'd0, 1'b1, 13'h0011, 1'b1, 1'b1, 13'h0011, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 9'd0, 1'b1, 13'h0012, 1'b1, 1'b1, 13'h0012, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 9'd0, 1'b1, 13'h0013, 1'b1, 1'b1, 13'h0013, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 9'd0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 9'd0, 1'b0, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0};

        // reset state
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b1);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);

        // 1: four beats streamed straight through
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].st, tbl[i].rows, tbl[i].iv, tbl[i].d, tbl[i].rdy, 1'b0);
            chk($sformatf("t1_valid%0d", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("t1_data%0d", i),  {19'd0, out_data},  {19'd0, tbl[i].e_data});
            chk($sformatf("t1_busy%0d", i),  {31'd0, busy},      {31'd0, tbl[i].e_busy});
            chk($sformatf("t1_done%0d", i),  {31'd0, done},      {31'd0, tbl[i].e_done});
            chk($sformatf("t1_ovf%0d", i),   {31'd0, overflow},  {31'd0, tbl[i].e_ovf});
        end

        // 2: twenty beats into a stalled host, last four dropped
        step(1'b1, 9'd20, 1'b0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 9'd0, 1'b1, 13'(i), 1'b0, 1'b0);
        chk("t2_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", {19'd0, out_data}, i);
            step(1'b0, 9'd0, 1'b0, 13'd0, 1'b1, 1'b0);
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);

        // 3: full FIFO with simultaneous push and pop
        step(1'b1, 9'd17, 1'b0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 9'd0, 1'b1, 13'(100 + i), 1'b0, 1'b0);
        step(1'b0, 9'd0, 1'b1, 13'd200, 1'b1, 1'b0);
        chk("t3_ovf",  {31'd0, overflow}, 32'd0);
        chk("t3_head", {19'd0, out_data}, 32'd101);
        n = 0;
        for (int i = 0; i < 40 && out_valid; i++) begin
            n++;
            step(1'b0, 9'd0, 1'b0, 13'd0, 1'b1, 1'b0);
        end
        chk("t3_count", n, 32'd16);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);

        // 4: zero-row job
        step(1'b1, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);
        chk("t4_done_once", {31'd0, done}, 32'd0);

        // 5: reset mid-collect, then a fresh job
        step(1'b1, 9'd10, 1'b0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 9'd0, 1'b1, 13'(50 + i), 1'b0, 1'b0);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b1);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_busy",  {31'd0, busy},      32'd0);
        step(1'b1, 9'd1, 1'b0, 13'd0, 1'b0, 1'b0);
        chk("t5_restart", {31'd0, busy}, 32'd1);
        step(1'b0, 9'd0, 1'b1, 13'd77, 1'b0, 1'b0);
        chk("t5_data", {19'd0, out_data}, 32'd77);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b1, 1'b0);
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);

`ifdef SMVM_ROWIDX_EN
        // 6: row indices travel with the data
        step(1'b1, 9'd3, 1'b0, 13'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 9'd0, 1'b1, 13'(7 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_row",  {23'd0, out_row},  i);
            chk("t6_data", {19'd0, out_data}, 7 + i);
            step(1'b0, 9'd0, 1'b0, 13'd0, 1'b1, 1'b0);
        end
        step(1'b0, 9'd0, 1'b0, 13'd0, 1'b0, 1'b0);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) == 0),
                 (($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 30))),
                 ($urandom_range(0, 1) == 1),
                 13'($urandom),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
